// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: state encoding, opcode/ALUOp/select constants and opcode dispatch for the multicycle control FSM
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_JALR   = 4'd12,
        S_LUI    = 4'd13,
        S_AUIPC  = 4'd14,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LUI   = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // Unknown opcodes fall into TRAP, which only reset leaves
    function automatic state_t dispatch(logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE: return S_MEMADR;
            OPC_OP:              return S_EXECR;
            OPC_OPIMM:           return S_EXECI;
            OPC_BRANCH:          return S_BRANCH;
            OPC_JAL:             return S_JAL;
            OPC_JALR:            return S_JALR;
            OPC_LUI:             return S_LUI;
            OPC_AUIPC:           return S_AUIPC;
            default:             return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// ctrl_output_decode: combinational state -> datapath control word, with memory-handshake gating
module ctrl_output_decode
    import core_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       reg_write,
    output logic [1:0] mem_to_reg
);

    // Everything defaults to 0 so IDLE, TRAP and any unlisted state assert nothing
    always_comb begin
        alu_op        = ALUOP_ADD;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        reg_write     = 1'b0;
        mem_to_reg    = M2R_ALUOUT;
        case (state)
            S_FETCH:  begin mem_read = 1'b1; alu_src_b = SRCB_4; ir_write = mem_ready; pc_write = mem_ready; end
            S_DECODE: begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
            S_MEMADR: begin alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; end
            S_MEMRD:  begin mem_read = 1'b1; iord = 1'b1; end
            S_MEMWB:  begin reg_write = mem_ready; mem_to_reg = M2R_MDR; end
            S_MEMWR:  begin mem_write = 1'b1; iord = 1'b1; end
            S_EXECR:  begin alu_src_a = SRCA_RS1; alu_op = ALUOP_FUNCT; end
            S_EXECI:  begin alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; alu_op = ALUOP_FUNCT; end
            S_ALUWB:  reg_write = 1'b1;
            S_BRANCH: begin alu_src_a = SRCA_RS1; alu_op = ALUOP_BR; pc_write_cond = 1'b1; pc_source = PCSRC_ALUOUT; end
            S_JAL:    begin pc_write = 1'b1; pc_source = PCSRC_ALUOUT; reg_write = 1'b1; mem_to_reg = M2R_PC; end
            S_JALR:   begin alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; pc_write = 1'b1; pc_source = PCSRC_JALR; reg_write = 1'b1; mem_to_reg = M2R_PC; end
            S_LUI:    begin alu_src_b = SRCB_IMM; alu_op = ALUOP_LUI; end
            S_AUIPC:  begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: RV32I multicycle sequencer with retired-instruction counter and sticky illegal flag
module multicycle_control_fsm
    import core_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t state_q;
    state_t nxt;
    logic   is_store;

    assign state = state_q;

    // Next state; single-cycle states not listed fall back to FETCH
    always_comb begin
        nxt = state_q;
        case (state_q)
            S_IDLE:                            nxt = run ? S_FETCH : S_IDLE;
            S_FETCH:                           nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:                          nxt = dispatch(opcode);
            S_MEMADR:                          nxt = is_store ? S_MEMWR : S_MEMRD;
            S_MEMRD:                           nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:                           nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR, S_EXECI, S_LUI, S_AUIPC:  nxt = S_ALUWB;
            S_TRAP:                            nxt = S_TRAP;
            default:                           nxt = S_FETCH;
        endcase
    end

    // State, load/store flag, sticky illegal and retire count; a fetch stall is not a retirement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            is_store <= 1'b0;
            illegal  <= 1'b0;
            retired  <= '0;
        end else begin
            state_q <= nxt;
            if (state_q == S_DECODE) is_store <= opcode[5];
            if (nxt == S_TRAP) illegal <= 1'b1;
            if (nxt == S_FETCH && state_q != S_IDLE && state_q != S_FETCH) retired <= retired + 1'b1;
        end
    end

    ctrl_output_decode u_dec (
        .state         (state_q),
        .mem_ready     (mem_ready),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: instruction-level reference model driving and checking the multicycle control FSM
module tb_multicycle_control_fsm;
    import core_ctrl_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [6:0]    opcode = '0;
    logic          mem_ready = 1'b0;
    logic [1:0]    alu_op, alu_src_a, alu_src_b, pc_source, mem_to_reg;
    logic          iord, mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write;
    logic          illegal;
    logic [3:0]    state;
    logic [CW-1:0] retired;
    logic [16:0]   word;

    int         checks = 0;
    int         failures = 0;
    int         cnt = 0;
    logic       ill_m = 1'b0;
    logic       go = 1'b0;
    logic [6:0] cur_opc = '0;
    logic [6:0] legal [9];

    multicycle_control_fsm #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .illegal       (illegal),
        .state         (state),
        .retired       (retired)
    );

    assign word = {alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
                   pc_write, pc_write_cond, pc_source, reg_write, mem_to_reg};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control word per state, fields in the order of 'word'
    function automatic logic [16:0] ctl(input state_t s, input logic r);
        case (s)
            S_FETCH:  return {2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, r,    r,    1'b0, 2'b00, 1'b0, 2'b00};
            S_DECODE: return {2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
            S_MEMADR: return {2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
            S_MEMRD:  return {2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
            S_MEMWB:  return {2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, r,    2'b01};
            S_MEMWR:  return {2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
            S_EXECR:  return {2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
            S_EXECI:  return {2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
            S_ALUWB:  return {2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00};
            S_BRANCH: return {2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00};
            S_JAL:    return {2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 2'b10};
            S_JALR:   return {2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10};
            S_LUI:    return {2'b11, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
            S_AUIPC:  return {2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
            default:  return '0;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    // One cycle: drive inputs at the falling edge, then check the expected state and outputs
    task automatic step(input state_t st, input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        run = (st == S_IDLE) ? go : rnd();
        opcode = (st == S_DECODE) ? cur_opc : 7'($urandom);
        if (st == S_TRAP) ill_m = 1'b1;
        #1;
        chk("state", 32'(state), 32'(st));
        chk("ctl", 32'(word), 32'(ctl(st, rdy)));
        chk("retired", 32'(retired), 32'(cnt % (1 << CW)));
        chk("illegal", 32'(illegal), 32'(ill_m));
    endtask

    // Whole instruction as a sequence of expected steps; retires on completion unless trapped
    task automatic instr(input logic [6:0] opc, input int fw, input int mw);
        cur_opc = opc;
        repeat (fw) step(S_FETCH, 1'b0);
        step(S_FETCH, 1'b1);
        step(S_DECODE, rnd());
        case (opc)
            OPC_LOAD:   begin step(S_MEMADR, rnd()); repeat (mw) step(S_MEMRD, 1'b0); step(S_MEMRD, 1'b1); step(S_MEMWB, rnd()); end
            OPC_STORE:  begin step(S_MEMADR, rnd()); repeat (mw) step(S_MEMWR, 1'b0); step(S_MEMWR, 1'b1); end
            OPC_OP:     begin step(S_EXECR, rnd()); step(S_ALUWB, rnd()); end
            OPC_OPIMM:  begin step(S_EXECI, rnd()); step(S_ALUWB, rnd()); end
            OPC_BRANCH: step(S_BRANCH, rnd());
            OPC_JAL:    step(S_JAL, rnd());
            OPC_JALR:   step(S_JALR, rnd());
            OPC_LUI:    begin step(S_LUI, rnd()); step(S_ALUWB, rnd()); end
            OPC_AUIPC:  begin step(S_AUIPC, rnd()); step(S_ALUWB, rnd()); end
            default:    begin step(S_TRAP, rnd()); return; end
        endcase
        cnt++;
    endtask

    initial begin
        legal = '{OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
        #1;
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_ctl", 32'(word), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(S_IDLE, rnd());
        go = 1'b1;
        step(S_IDLE, rnd());
        instr(OPC_OP, 0, 0);
        instr(OPC_LOAD, 0, 3);
        instr(OPC_BRANCH, 1, 0);
        instr(OPC_STORE, 2, 2);
        instr(OPC_JAL, 0, 0);
        instr(OPC_JALR, 0, 0);
        instr(OPC_LUI, 0, 0);
        instr(OPC_AUIPC, 0, 0);
        instr(OPC_OPIMM, 0, 0);
        repeat (40) instr(legal[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3));
        cur_opc = OPC_STORE;
        step(S_FETCH, 1'b1);
        step(S_DECODE, rnd());
        step(S_MEMADR, rnd());
        step(S_MEMWR, 1'b0);
        step(S_MEMWR, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        cnt = 0;
        chk("async_memwrite", 32'(mem_write), 32'd0);
        chk("async_ctl", 32'(word), 32'd0);
        chk("async_state", 32'(state), 32'(S_IDLE));
        chk("async_retired", 32'(retired), 32'd0);
        chk("async_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(S_IDLE, rnd());
        instr(OPC_OP, 0, 0);
        instr(7'b1111111, 0, 0);
        repeat (99) step(S_TRAP, rnd());
        @(negedge clk);
        rst_n = 1'b0;
        ill_m = 1'b0;
        #1;
        chk("final_state", 32'(state), 32'(S_IDLE));
        chk("final_illegal", 32'(illegal), 32'd0);
        chk("final_retired", 32'(retired), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
